imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipeline's IF stage.
- Owns the program counter and drives the word address into the combinational instruction memory, which returns data in the same cycle.
- Buffers fetched words with their PCs in a small FIFO, presented to decode over a valid/ready handshake.
- Handles start/halt control, branch/jump redirect with flush, and out-of-range fetch detection.

Parameters:
- RESET_PC, 32'h00000000, byte address loaded into the PC at reset.
- IMEM_WORDS, 128, instruction memory depth in 32-bit words; any word index at or above this value is out of range.
- FIFO_DEPTH, 2, fetch buffer entries (2..8).
- CNT_W, 2, width of fifo_count; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; IDLE->RUN.
- halt  in  1  pulse; RUN->IDLE.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  byte target; bits [1:0] ignored (treated as 0).
- imem_addr  out  32  word index to instruction memory = {2'b00, pc[31:2]}; combinational from pc.
- imem_data  in  32  instruction word from memory, valid in the same cycle as imem_addr.
- if_valid  out  1  FIFO head valid.
- if_instr  out  32  head instruction.
- if_pc  out  32  byte PC of the head instruction.
- id_ready  in  1  decode accepts head.
- fifo_count  out  CNT_W  current occupancy.
- addr_err  out  1  sticky; an out-of-range fetch occurred.
- fetch_count  out  32  number of enqueued fetches, wraps at 2^32.
- running  out  1  state==RUN.

Behaviour:
- Reset (async, rst=1) values:
  - pc=RESET_PC, state=IDLE, FIFO empty, fifo_count=0.
  - if_valid=0, if_instr=0, if_pc=0.
  - addr_err=0, fetch_count=0, running=0.
- Reset mid-operation discards all FIFO contents immediately.
- State machine:
  - IDLE: no fetch. start=1 -> RUN.
  - RUN: fetch each eligible cycle. halt=1 -> IDLE; halt wins over start if both are high.
  - Leaving RUN stops enqueueing from the next edge; the FIFO keeps draining to decode.
- pop = if_valid & id_ready.
- push = running & ~redirect_valid & (fifo_count<FIFO_DEPTH | pop).
  - Simultaneous push and pop with a full FIFO is legal; count is unchanged.
- On push: the entry {instr, pc} is written at the FIFO tail, then pc<=pc+4 (mod 2^32) and fetch_count<=fetch_count+1.
  - instr = imem_data when pc[31:2]<IMEM_WORDS.
  - Otherwise instr = 32'h00000000 (NOP) and addr_err<=1.
- Latency: a word fetched in cycle N appears at if_* in cycle N+1 if the FIFO was empty. if_* are registered (head entry), not combinational from imem_data.
- FIFO order is strict first-in/first-out. fifo_count = pushes - pops.
- When empty: if_valid=0, and if_instr/if_pc hold their last values. id_ready is a don't-care.
- Redirect (highest priority, any state):
  - The FIFO is flushed in that cycle, including any simultaneous pop; the pop is still treated as consumed by decode.
  - pc<={redirect_pc[31:2],2'b00}; no push that cycle.
  - if_valid=0 from the next cycle.
  - State is unchanged (redirect in IDLE only loads the pc).
- Redirect and halt in the same cycle: both take effect.
- addr_err clears only on rst; redirect does not clear it.
- pc wrap from 32'hFFFFFFFC to 0 is legal, and that fetch is flagged out of range per the IMEM_WORDS rule.
- fetch_count wraps silently.

Test Plan:
- Basic fetch: imem model holds 0x002300AA, 0x10654321, 0x00200022, 0x8C123456 at words 0..3; rst, start, id_ready=1 -> if_valid from cycle 2; if_instr sequence 0x002300AA, 0x10654321, 0x00200022, 0x8C123456 with if_pc 0,4,8,12; imem_addr 0,1,2,3; fetch_count increments each cycle.
- Backpressure: id_ready=0 for 5 cycles in RUN -> fifo_count saturates at 2, pc stops at 8, head stays 0x002300AA@0; release id_ready -> next instr 0x10654321@4 with no loss or duplication.
- Redirect flush: FIFO full, redirect_valid with redirect_pc=0x0000001F -> next cycle if_valid=0, fifo_count=0, imem_addr=7; following cycle if_pc=0x1C.
- Halt/start: halt while 2 entries buffered -> running=0, both entries drain in order, pc frozen; start -> fetching resumes at the frozen pc.
- Out of range: redirect_pc=0x000001FC then 0x00000200 (word 128) -> word 127 data enqueued, then if_instr=0x00000000, addr_err=1 stays high after a later redirect to 0.
- Async reset mid-run: assert rst between edges with FIFO non-empty -> if_valid, fifo_count and running drop to 0 immediately, pc=RESET_PC, no fetch until start.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - IF-stage fetch sequencer: PC, fetch FIFO, redirect flush, range check
// FIFO head is always entry 0, so if_instr/if_pc keep their last value once drained or flushed.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 128,
   parameter int          FIFO_DEPTH = 2,
   parameter int          CNT_W      = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_data,
   output logic             if_valid,
   output logic [31:0]      if_instr,
   output logic [31:0]      if_pc,
   input  logic             id_ready,
   output logic [CNT_W-1:0] fifo_count,
   output logic             addr_err,
   output logic [31:0]      fetch_count,
   output logic             running
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                      state_q, state_d;
   logic [31:0]                 pc_q, pc_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d, wr_idx;
   logic                        err_q, err_d;
   logic [31:0]                 fcnt_q, fcnt_d;
   logic [FIFO_DEPTH-1:0][31:0] ins_q, ins_d, ins_sh;
   logic [FIFO_DEPTH-1:0][31:0] pcs_q, pcs_d, pcs_sh;
   logic                        pop, push, full, in_range;
   logic [31:0]                 fetch_instr;

   assign imem_addr   = {2'b00, pc_q[31:2]};
   assign if_valid    = (cnt_q != '0);
   assign if_instr    = ins_q[0];
   assign if_pc       = pcs_q[0];
   assign fifo_count  = cnt_q;
   assign addr_err    = err_q;
   assign fetch_count = fcnt_q;
   assign running     = (state_q == ST_RUN);

   assign in_range    = (pc_q[31:2] < 30'(IMEM_WORDS));
   assign fetch_instr = in_range ? imem_data : 32'h0000_0000;
   assign ins_sh      = {32'h0, ins_q[FIFO_DEPTH-1:1]};
   assign pcs_sh      = {32'h0, pcs_q[FIFO_DEPTH-1:1]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (halt)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pop    = if_valid & id_ready;
      full   = (cnt_q == CNT_W'(FIFO_DEPTH));
      push   = running & ~redirect_valid & (~full | pop);
      wr_idx = pop ? (cnt_q - CNT_W'(1)) : cnt_q;

      pc_d   = pc_q;
      cnt_d  = cnt_q;
      err_d  = err_q | (push & ~in_range);
      fcnt_d = fcnt_q + 32'(push);
      ins_d  = ins_q;
      pcs_d  = pcs_q;

      if (redirect_valid) begin
         pc_d  = {redirect_pc[31:2], 2'b00};
         cnt_d = '0;
      end else begin
         if (push) pc_d = pc_q + 32'd4;
         if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
         else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      end

      // A flush leaves entries untouched so the held head value survives.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (push && (CNT_W'(i) == wr_idx)) begin
            ins_d[i] = fetch_instr;
            pcs_d[i] = pc_q;
         end else if (pop && !redirect_valid && (CNT_W'(i + 1) < cnt_q)) begin
            ins_d[i] = ins_sh[i];
            pcs_d[i] = pcs_sh[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         fcnt_q  <= '0;
         ins_q   <= '0;
         pcs_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fcnt_q  <= fcnt_d;
         ins_q   <= ins_d;
         pcs_q   <= pcs_d;
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - randomized self-checking bench for imem_fetch_ctrl against a queue model
module tb_imem_fetch_ctrl;

   localparam int DEPTH = 2;
   localparam int WORDS = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, halt, redirect_valid, id_ready;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr, imem_data;
   logic        if_valid;
   logic [31:0] if_instr, if_pc;
   logic [1:0]  fifo_count;
   logic        addr_err;
   logic [31:0] fetch_count;
   logic        running;

   logic [31:0] mem [WORDS];

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] q_ins[$];
   logic [31:0] q_pc[$];
   logic [31:0] m_pc, m_fcnt, m_hi, m_hp;
   logic        m_run, m_err;

   imem_fetch_ctrl #(
      .RESET_PC  (32'h0000_0000),
      .IMEM_WORDS(WORDS),
      .FIFO_DEPTH(DEPTH),
      .CNT_W     (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .halt          (halt),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .if_valid      (if_valid),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .id_ready      (id_ready),
      .fifo_count    (fifo_count),
      .addr_err      (addr_err),
      .fetch_count   (fetch_count),
      .running       (running)
   );

   always #5 clk = ~clk;

   // Out-of-range addresses return garbage; the DUT must substitute a NOP.
   assign imem_data = (imem_addr < 32'(WORDS)) ? mem[imem_addr[6:0]] : 32'hDEAD_BEEF;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_ins.delete();
      q_pc.delete();
      m_pc   = 32'h0;
      m_fcnt = 32'h0;
      m_hi   = 32'h0;
      m_hp   = 32'h0;
      m_run  = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic model_step();
      bit          pop, push;
      logic [31:0] word, ins;
      pop = (q_ins.size() != 0) && id_ready;
      if (redirect_valid) begin
         q_ins.delete();
         q_pc.delete();
         m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         push = m_run && ((q_ins.size() < DEPTH) || pop);
         if (pop) begin
            void'(q_ins.pop_front());
            void'(q_pc.pop_front());
         end
         if (push) begin
            word = m_pc >> 2;
            if (word < 32'(WORDS)) ins = mem[word[6:0]];
            else begin
               ins   = 32'h0;
               m_err = 1'b1;
            end
            q_ins.push_back(ins);
            q_pc.push_back(m_pc);
            m_pc   = m_pc + 32'd4;
            m_fcnt = m_fcnt + 32'd1;
         end
      end
      if (q_ins.size() != 0) begin
         m_hi = q_ins[0];
         m_hp = q_pc[0];
      end
      if (!m_run) m_run = start;
      else if (halt) m_run = 1'b0;
   endtask

   task automatic compare_all();
      check_val("if_valid",    32'(if_valid),    32'(q_ins.size() != 0));
      check_val("fifo_count",  32'(fifo_count),  32'(q_ins.size()));
      check_val("running",     32'(running),     32'(m_run));
      check_val("imem_addr",   imem_addr,        m_pc >> 2);
      check_val("addr_err",    32'(addr_err),    32'(m_err));
      check_val("fetch_count", fetch_count,      m_fcnt);
      check_val("if_instr",    if_instr,         m_hi);
      check_val("if_pc",       if_pc,            m_hp);
   endtask

   task automatic step(input logic s, input logic h, input logic rv,
                       input logic [31:0] rp, input logic rdy);
      start          = s;
      halt           = h;
      redirect_valid = rv;
      redirect_pc    = rp;
      id_ready       = rdy;
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic        s, h, rv, rdy;
      logic [31:0] rp;
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
      mem[0] = 32'h0023_00AA;
      mem[1] = 32'h1065_4321;
      mem[2] = 32'h0020_0022;
      mem[3] = 32'h8C12_3456;

      rst = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'h0; id_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b0;

      // basic fetch stream
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // backpressure, then release
      rst = 1'b1; model_reset(); @(negedge clk); rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check_val("bp_head", if_instr, 32'h0023_00AA);
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // redirect flush on a full FIFO
      repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_001F, 1'b0);
      check_val("redir_addr", imem_addr, 32'd7);
      repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // halt with buffered entries, drain, restart
      repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // out-of-range boundary and sticky error
      step(1'b0, 1'b0, 1'b1, 32'h0000_01FC, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // pc wrap through 0xFFFFFFFC
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // async reset between edges with a non-empty FIFO
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      #1 rst = 1'b0;
      @(negedge clk);
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         s   = ($urandom_range(0, 5) == 0);
         h   = ($urandom_range(0, 15) == 0);
         rv  = ($urandom_range(0, 11) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else                           rp = 32'($urandom_range(0, 560));
         step(s, h, rv, rp, rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
